pulse_event_arbiter: RTL and testbench

Collects one-cycle event strobes from up to N `async2sync`-style synchronizers and hands them one at a time, round-robin, to a single shared consumer over a valid/ready handshake. Each channel holds one pending event; an event arriving while its channel is already pending is counted as lost. The block sits between the per-source pulse synchronizers and the shared command/register port in the inouttraffic clock domain.

---
 rtl/pulse_event_arbiter.sv | 121 ++++++++++++
 tb/tb_pulse_event_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: one-deep per-channel event latches served round-robin to a
// single valid/ready consumer. Define PULSE_ARB_LOST_CNT_EN to build the lost_cnt counters.
module pulse_event_arbiter #(
    parameter int N         = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           ev_in,
    output logic                   out_valid,
    output logic [ID_WIDTH-1:0]    out_id,
    input  logic                   out_ready,
    input  logic                   lost_clr,
    output logic [N-1:0]           lost_flag,
    output logic [N*CNT_WIDTH-1:0] lost_cnt,
    output logic                   busy
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        req, above_mask, req_above, load_mask, loss;
    logic [IW-1:0]       last_q, start_idx, grant_idx;
    logic                load_en;
    logic [ID_WIDTH-1:0] out_id_q;
    logic [N-1:0]        lost_flag_q;

    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (v[IW'(i - 1)]) lowest_set = IW'(i - 1);
        end
    endfunction

    // A strobe arriving on a loadable edge competes directly with the latched
    // events, so an idle block offers it one cycle later.
    always_comb begin
        req        = pending_q | ev_in;
        start_idx  = (last_q == IW'(N - 1)) ? '0 : last_q + IW'(1);
        above_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            above_mask[IW'(i)] = (IW'(i) >= start_idx);
        end
        req_above = req & above_mask;
        grant_idx = (|req_above) ? lowest_set(req_above) : lowest_set(req);
    end

    always_comb begin
        load_en   = ((state_q == S_IDLE) || out_ready) && (|req);
        load_mask = load_en ? (N'(1) << grant_idx) : '0;
        // Loaded channel keeps a bit only for a second event beyond the one consumed.
        pending_d = (load_mask & pending_q & ev_in) | (~load_mask & req);
        loss      = ev_in & pending_q & ~load_mask;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_en) state_d = S_OFFER;
            S_OFFER: if (out_ready && !load_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            last_q      <= IW'(N - 1);
            out_id_q    <= '0;
            lost_flag_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (load_en) begin
                last_q   <= grant_idx;
                out_id_q <= ID_WIDTH'(grant_idx);
            end
            lost_flag_q <= lost_clr ? loss : (lost_flag_q | loss);
        end
    end

`ifdef PULSE_ARB_LOST_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) cnt_q[IW'(i)] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (lost_clr)
                    cnt_q[IW'(i)] <= CNT_WIDTH'(loss[IW'(i)]);
                else if (loss[IW'(i)] && (cnt_q[IW'(i)] != '1))
                    cnt_q[IW'(i)] <= cnt_q[IW'(i)] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        lost_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lost_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[IW'(i)];
        end
    end
`else
    assign lost_cnt = '0;
`endif

    assign out_valid = (state_q == S_OFFER);
    assign out_id    = out_id_q;
    assign lost_flag = lost_flag_q;
    assign busy      = (|pending_q) | out_valid;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: directed scenarios plus random traffic against an
// event-level reference model of the arbitration rules.
module tb_pulse_event_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int CW   = 8;
    localparam int VW   = 1 + IDW + N + N*CW + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ev_in = '0;
    logic            out_ready = 1'b0;
    logic            lost_clr = 1'b0;
    logic            out_valid;
    logic [IDW-1:0]  out_id;
    logic [N-1:0]    lost_flag;
    logic [N*CW-1:0] lost_cnt;
    logic            busy;
    logic [VW-1:0]   dut_vec;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_pend [N];
    bit m_flag [N];
    int m_cnt  [N];
    bit m_valid;
    int m_id;
    int m_last;

    always #5 clk = ~clk;

    pulse_event_arbiter #(.N(N), .ID_WIDTH(IDW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .out_valid(out_valid),
        .out_id(out_id), .out_ready(out_ready), .lost_clr(lost_clr),
        .lost_flag(lost_flag), .lost_cnt(lost_cnt), .busy(busy)
    );

    assign dut_vec = {out_valid, out_id, lost_flag, lost_cnt, busy};

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_flag[i] = 0; m_cnt[i] = 0;
        end
        m_valid = 0; m_id = 0; m_last = N - 1;
    endfunction

    function automatic void m_step(input logic [N-1:0] ev, input logic rdy, input logic clr);
        int g;
        int c;
        bit l;
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (g < 0 && (m_pend[c] || ev[c])) g = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            l = ev[i] && m_pend[i] && (i != g);
            m_pend[i] = (i == g) ? (m_pend[i] && ev[i]) : (m_pend[i] || ev[i]);
            if (clr) begin
                m_flag[i] = l;
                m_cnt[i]  = l ? 1 : 0;
            end else if (l) begin
                m_flag[i] = 1;
                if (m_cnt[i] < CMAX) m_cnt[i]++;
            end
        end
        if (g >= 0) begin
            m_valid = 1; m_id = g; m_last = g;
        end else if (rdy) begin
            m_valid = 0;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]    fl;
        logic [N*CW-1:0] cn;
        logic            bz;
        bz = m_valid;
        cn = '0;
        for (int i = 0; i < N; i++) begin
            fl[i] = m_flag[i];
            bz    = bz | m_pend[i];
`ifdef PULSE_ARB_LOST_CNT_EN
            cn[i*CW +: CW] = CW'(m_cnt[i]);
`endif
        end
        return {m_valid, IDW'(m_id), fl, cn, bz};
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef PULSE_ARB_LOST_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step(ev_in, out_ready, lost_clr);
        #1;
    endtask

    task automatic do_reset();
        ev_in = '0; out_ready = 1'b0; lost_clr = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (dut_vec !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
        tick();
        n_vec++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        ev_in = 4'b0100; out_ready = 1'b1;
        tick();
        ev_in = '0;
        n_vec++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            n_err++;
            $display("FAIL single_offer: got valid=%b id=%0d expected valid=1 id=2", out_valid, out_id);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        n_vec++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL single_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_all_four();
        do_reset();
        ev_in = 4'b1111; out_ready = 1'b1;
        tick();
        ev_in = '0;
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_id !== IDW'(k) || lost_flag !== '0) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got valid=%b id=%0d flags=%b expected 1 %0d 0000",
                         k, out_valid, out_id, lost_flag, k);
            end
            tick();
        end
        n_vec++;
        if (dut_vec !== exp_vec() || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drain: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_loss();
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            ev_in = 4'b0010;
            tick();
            ev_in = '0;
            tick();
        end
        n_vec++;
        if (lost_flag !== 4'b0010 || int'(lost_cnt[1*CW +: CW]) !== exp_cnt(1)
            || out_valid !== 1'b1 || out_id !== 2'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL loss_three: got flags=%b cnt1=%0d valid=%b id=%0d expected 0010 %0d 1 1",
                     lost_flag, lost_cnt[1*CW +: CW], out_valid, out_id, exp_cnt(1));
        end
        n_vec++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL loss_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            ev_in = (k < 2) ? 4'b0011 : 4'b0001;
            tick();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL sat_step[%0d]: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        ev_in = '0;
        n_vec++;
        if (int'(lost_cnt[CW-1:0]) !== exp_cnt(255) || lost_flag !== 4'b0011) begin
            n_err++;
            $display("FAIL sat_value: got cnt0=%0d flags=%b expected %0d 0011",
                     lost_cnt[CW-1:0], lost_flag, exp_cnt(255));
        end
        ev_in = 4'b0001; lost_clr = 1'b1;
        tick();
        ev_in = '0; lost_clr = 1'b0;
        n_vec++;
        if (lost_flag !== 4'b0001 || int'(lost_cnt[CW-1:0]) !== exp_cnt(1)
            || lost_cnt[2*CW-1:CW] !== '0) begin
            n_err++;
            $display("FAIL clr_with_loss: got flags=%b cnt0=%0d cnt1=%0d expected 0001 %0d 0",
                     lost_flag, lost_cnt[CW-1:0], lost_cnt[2*CW-1:CW], exp_cnt(1));
        end
    endtask

    task automatic test_reoffer();
        int exp_ids[3];
        exp_ids[0] = 3; exp_ids[1] = 1; exp_ids[2] = 3;
        do_reset();
        out_ready = 1'b0;
        ev_in = 4'b1000;
        tick();
        ev_in = 4'b1010;
        tick();
        ev_in = '0;
        tick();
        n_vec++;
        if (out_id !== 2'd3 || lost_flag !== '0 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reoffer_hold: got %h expected %h", dut_vec, exp_vec());
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_id !== IDW'(exp_ids[k]) || lost_flag !== '0) begin
                n_err++;
                $display("FAIL reoffer_seq[%0d]: got valid=%b id=%0d flags=%b expected 1 %0d 0000",
                         k, out_valid, out_id, lost_flag, exp_ids[k]);
            end
        end
        tick();
        n_vec++;
        if (dut_vec !== exp_vec() || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reoffer_end: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        ev_in = 4'b0101;
        tick();
        ev_in = '0;
        n_vec++;
        if (out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL arst_pre: got %h expected %h", dut_vec, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL arst_immediate: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_stale[%0d]: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        ev_in = 4'b0010;
        tick();
        ev_in = '0;
        n_vec++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL arst_after: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            ev_in     = N'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            lost_clr  = ($urandom_range(0, 40) == 0);
            if (k % 200 > 150) out_ready = 1'b0;
            tick();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        ev_in = '0; out_ready = 1'b0; lost_clr = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_all_four();
        test_loss();
        test_saturate();
        test_reoffer();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
